// File: rtl/tv_bt656_decoder.sv
// BT.656 byte-stream decoder.
// Tracks TRS preambles (FF 00 00 XY), validates the XY protection bits and
// turns the Cb-Y-Cr-Y active video between SAV and EAV into 16-bit pixels.
// Each pixel carries a 1-based x/y position and a running pixel index
// within the field. Every output is registered.
module tv_bt656_decoder #(
  parameter int H_ACTIVE = 720,
  parameter int Y_MAX    = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  td_data,
  output logic        tv_field,
  output logic [20:0] tv_lin,
  output logic        tv_dval,
  output logic [9:0]  tv_x,
  output logic [9:0]  tv_y,
  output logic [15:0] data_out,
  output logic        sync_err
);

  localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
  localparam logic [9:0] Y_LIM = 10'(Y_MAX);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_FF     = 2'd1,
    S_00     = 2'd2,
    S_0000   = 2'd3
  } trs_state_t;

  // Checks an XY byte: the marker bit must be set and the four protection
  // bits must match the F/V/H flags.
  function automatic logic xy_ok(input logic [7:0] xy);
    logic f;
    logic v;
    logic h;
    f = xy[6];
    v = xy[5];
    h = xy[4];
    return xy[7] && (xy[3:0] == {v ^ h, f ^ h, f ^ v, f ^ v ^ h});
  endfunction

  trs_state_t  trs_q, trs_d;
  logic        cap_q, cap_d;
  logic [1:0]  phase_q, phase_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [20:0] lin_q, lin_d;
  logic [7:0]  c_q, c_d;

  logic        field_q, field_d;
  logic        dval_q, dval_d;
  logic [9:0]  tvx_q, tvx_d;
  logic [9:0]  tvy_q, tvy_d;
  logic [20:0] tvlin_q, tvlin_d;
  logic [15:0] dout_q, dout_d;
  logic        serr_q, serr_d;

  logic        xy_valid_s;
  logic        xy_bad_s;
  logic        trs_byte_s;

  // TRS preamble recogniser: one transition per byte.
  always_comb begin
    trs_d = S_SEARCH;
    case (trs_q)
      S_SEARCH: begin
        if (td_data == 8'hFF) begin
          trs_d = S_FF;
        end else begin
          trs_d = S_SEARCH;
        end
      end
      S_FF: begin
        if (td_data == 8'h00) begin
          trs_d = S_00;
        end else if (td_data == 8'hFF) begin
          trs_d = S_FF;
        end else begin
          trs_d = S_SEARCH;
        end
      end
      S_00: begin
        if (td_data == 8'h00) begin
          trs_d = S_0000;
        end else if (td_data == 8'hFF) begin
          trs_d = S_FF;
        end else begin
          trs_d = S_SEARCH;
        end
      end
      S_0000: trs_d = S_SEARCH;
      default: trs_d = S_SEARCH;
    endcase
  end

  // Classify the current byte: XY decode result, and whether it belongs to
  // a TRS (a 00 after FF, or the XY itself). FF/00 never occur as legal
  // video, so such a byte is never turned into a pixel.
  always_comb begin
    xy_valid_s = 1'b0;
    xy_bad_s   = 1'b0;
    trs_byte_s = 1'b0;
    if (trs_q == S_0000) begin
      xy_valid_s = xy_ok(td_data);
      xy_bad_s   = !xy_ok(td_data);
      trs_byte_s = 1'b1;
    end else if ((trs_q == S_FF || trs_q == S_00) && td_data == 8'h00) begin
      trs_byte_s = 1'b1;
    end else begin
      trs_byte_s = 1'b0;
    end
  end

  // Capture datapath and output next-state: pixel assembly, counters and
  // the effect of a valid XY (which overrides the capture update).
  always_comb begin
    cap_d   = cap_q;
    phase_d = phase_q;
    x_d     = x_q;
    y_d     = y_q;
    lin_d   = lin_q;
    c_d     = c_q;
    field_d = field_q;
    dval_d  = 1'b0;
    tvx_d   = tvx_q;
    tvy_d   = tvy_q;
    tvlin_d = tvlin_q;
    dout_d  = dout_q;
    serr_d  = xy_bad_s;

    if (cap_q) begin
      phase_d = phase_q + 2'd1;
      if (!phase_q[0]) begin
        // Chroma byte: Cb at phase 0, Cr at phase 2.
        c_d = td_data;
      end else if (!trs_byte_s) begin
        // Luma byte: emit a pixel while the line still has room.
        if (x_q < H_ACT) begin
          dval_d  = 1'b1;
          dout_d  = {td_data, c_q};
          tvx_d   = x_q + 10'd1;
          tvy_d   = y_q;
          tvlin_d = lin_q;
          x_d     = x_q + 10'd1;
          lin_d   = lin_q + 21'd1;
          if (x_q == H_ACT - 10'd1) begin
            cap_d = 1'b0;
          end else begin
            cap_d = 1'b1;
          end
        end else begin
          cap_d = 1'b0;
        end
      end else begin
        c_d = c_q;
      end
    end else begin
      phase_d = phase_q;
    end

    if (xy_valid_s) begin
      if (td_data[5]) begin
        // Vertical blanking: restart line and field pixel counting.
        y_d   = 10'd0;
        lin_d = 21'd0;
        cap_d = 1'b0;
      end else if (td_data[4]) begin
        // EAV: end of active line.
        cap_d = 1'b0;
      end else begin
        // SAV: new active line starts with the next byte.
        field_d = td_data[6];
        if (y_q >= Y_LIM) begin
          y_d = Y_LIM;
        end else begin
          y_d = y_q + 10'd1;
        end
        x_d     = 10'd0;
        phase_d = 2'd0;
        cap_d   = 1'b1;
      end
    end else begin
      field_d = field_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      trs_q   <= S_SEARCH;
      cap_q   <= 1'b0;
      phase_q <= 2'd0;
      x_q     <= 10'd0;
      y_q     <= 10'd0;
      lin_q   <= 21'd0;
      c_q     <= 8'd0;
      field_q <= 1'b0;
      dval_q  <= 1'b0;
      tvx_q   <= 10'd0;
      tvy_q   <= 10'd0;
      tvlin_q <= 21'd0;
      dout_q  <= 16'd0;
      serr_q  <= 1'b0;
    end else begin
      trs_q   <= trs_d;
      cap_q   <= cap_d;
      phase_q <= phase_d;
      x_q     <= x_d;
      y_q     <= y_d;
      lin_q   <= lin_d;
      c_q     <= c_d;
      field_q <= field_d;
      dval_q  <= dval_d;
      tvx_q   <= tvx_d;
      tvy_q   <= tvy_d;
      tvlin_q <= tvlin_d;
      dout_q  <= dout_d;
      serr_q  <= serr_d;
    end
  end

  assign tv_field = field_q;
  assign tv_lin   = tvlin_q;
  assign tv_dval  = dval_q;
  assign tv_x     = tvx_q;
  assign tv_y     = tvy_q;
  assign data_out = dout_q;
  assign sync_err = serr_q;

endmodule

// File: tb/tb_tv_bt656_decoder.sv
// Scoreboard bench for tv_bt656_decoder: stimulus pushes the expected pixel
// for every luma byte that should produce one; a negedge monitor pops and
// compares on each tv_dval strobe and counts sync_err pulses.
module tb_tv_bt656_decoder;

  logic        clk;
  logic        reset;
  logic [7:0]  td_data;
  logic        tv_field;
  logic [20:0] tv_lin;
  logic        tv_dval;
  logic [9:0]  tv_x;
  logic [9:0]  tv_y;
  logic [15:0] data_out;
  logic        sync_err;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [20:0] lin;
    logic [15:0] data;
    logic        field;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests;
  int   n_fail;
  int   serr_count;

  tv_bt656_decoder #(.H_ACTIVE(720), .Y_MAX(1023)) dut (
    .clk      (clk),
    .reset    (reset),
    .td_data  (td_data),
    .tv_field (tv_field),
    .tv_lin   (tv_lin),
    .tv_dval  (tv_dval),
    .tv_x     (tv_x),
    .tv_y     (tv_y),
    .data_out (data_out),
    .sync_err (sync_err)
  );

  // 27 MHz-ish byte clock (period 10 time units).
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    td_data = b;
  endtask

  task automatic send_trs(input logic [7:0] xy);
    send(8'hFF);
    send(8'h00);
    send(8'h00);
    send(xy);
  endtask

  // n pixels of the line pattern (C = 10/20 alternating, Y = pixel index);
  // the first n_emit of them are expected on the output.
  task automatic send_pixels(input int n, input logic [9:0] y, input logic [20:0] lin0,
                             input logic fld, input int n_emit);
    logic [7:0] c;
    logic [7:0] yb;
    exp_t       e;
    for (int k = 0; k < n; k++) begin
      c  = (k % 2 == 0) ? 8'h10 : 8'h20;
      yb = 8'(k);
      send(c);
      if (k < n_emit) begin
        e.x     = 10'(k + 1);
        e.y     = y;
        e.lin   = lin0 + 21'(k);
        e.data  = {yb, c};
        e.field = fld;
        exp_q.push_back(e);
      end
      send(yb);
    end
  endtask

  // Monitor: compare each strobe against the scoreboard, count sync_err.
  always @(negedge clk) begin
    exp_t e;
    if (sync_err) serr_count++;
    if (tv_dval) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got x=%0d y=%0d lin=%0d, required no pulse", tv_x, tv_y, tv_lin);
      end else begin
        e = exp_q.pop_front();
        if (tv_x !== e.x || tv_y !== e.y || tv_lin !== e.lin || data_out !== e.data || tv_field !== e.field) begin
          n_fail++;
          $display("FAIL pixel: got x=%0d y=%0d lin=%0d data=%h f=%0d, required x=%0d y=%0d lin=%0d data=%h f=%0d",
                   tv_x, tv_y, tv_lin, data_out, tv_field, e.x, e.y, e.lin, e.data, e.field);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    n_tests    = 0;
    n_fail     = 0;
    serr_count = 0;
    reset      = 1'b1;
    td_data    = 8'h00;

    // Reset with random bytes.
    for (int i = 0; i < 4; i++) send(8'($urandom));
    check("reset_dval", 32'(tv_dval), 32'd0);
    check("reset_x", 32'(tv_x), 32'd0);
    check("reset_y", 32'(tv_y), 32'd0);
    check("reset_lin", 32'(tv_lin), 32'd0);
    check("reset_data", 32'(data_out), 32'd0);
    check("reset_field", 32'(tv_field), 32'd0);
    check("reset_serr", 32'(sync_err), 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    td_data = 8'h10;

    // Blank line clears y, then one full line of 720 pixels.
    send_trs(8'hAB);
    send_trs(8'h80);
    send_pixels(720, 10'd1, 21'd0, 1'b0, 720);

    // Second line, truncated after 4 pixels by EAV.
    send_trs(8'h9D);
    send_trs(8'h80);
    send_pixels(4, 10'd2, 21'd720, 1'b0, 4);
    send_trs(8'h9D);

    // Field 2: blanking EC, SAV C7, two pixels, EAV DA.
    send_trs(8'hEC);
    send_trs(8'hC7);
    send_pixels(2, 10'd1, 21'd0, 1'b1, 2);
    send_trs(8'hDA);

    // Protection error: sync_err one cycle later, no capture.
    send_trs(8'h81);
    send(8'h10);
    check("serr_pulse", 32'(sync_err), 32'd1);
    send(8'h11);
    check("serr_single", 32'(sync_err), 32'd0);
    for (int i = 0; i < 8; i++) send(8'h40);
    check("serr_y_hold", 32'(tv_y), 32'd1);
    send_trs(8'h80);
    send_pixels(1, 10'd2, 21'd2, 1'b0, 1);
    send_trs(8'h9D);

    // EAV after 100 pixels.
    send_trs(8'h80);
    send_pixels(100, 10'd3, 21'd3, 1'b0, 100);
    send_trs(8'h9D);

    // Missing EAV: 1600 bytes, capture self-stops at 720.
    send_trs(8'h80);
    send_pixels(800, 10'd4, 21'd103, 1'b0, 720);
    send_trs(8'h9D);

    // Reset in the middle of the line at pixel 300.
    send_trs(8'h80);
    send_pixels(299, 10'd5, 21'd823, 1'b0, 299);
    send(8'h20);
    @(negedge clk);
    reset   = 1'b1;
    td_data = 8'h2B;
    @(negedge clk);
    check("midreset_dval", 32'(tv_dval), 32'd0);
    check("midreset_x", 32'(tv_x), 32'd0);
    check("midreset_y", 32'(tv_y), 32'd0);
    check("midreset_lin", 32'(tv_lin), 32'd0);
    check("midreset_data", 32'(data_out), 32'd0);
    reset   = 1'b0;
    td_data = 8'h10;
    for (int i = 0; i < 6; i++) send(8'h10);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("serr_count", 32'(serr_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tv_bt656_decoder.md
Name: tv_bt656_decoder

Overview:
Upstream stage of the active-window/address generator. Decodes an ITU-R BT.656 8-bit byte stream (27 MHz, 4:2:2 Cb-Y-Cr-Y) from the video ADC into 16-bit pixels with 1-based pixel/line coordinates, field flag, running field pixel count and a pixel-valid strobe. Its outputs connect directly to the tv_field/tv_lin/tv_dval/tv_x/tv_y/data_in inputs of the window stage.

Parameters:
H_ACTIVE, 720, active pixels per line; capture stops at this count even if EAV is late
Y_MAX, 1023, saturation value of line counter

Ports:
clk  in  1  byte clock, 27 MHz, one BT.656 byte per cycle
reset  in  1  synchronous, active-high
td_data  in  8  BT.656 byte stream
tv_field  out  1  F bit latched at last valid SAV (0 = field 1)
tv_lin  out  21  pixel index within field, 0 for first active pixel
tv_dval  out  1  one-cycle strobe, data_out/tv_x/tv_y/tv_lin valid
tv_x  out  10  pixel number in line, 1..H_ACTIVE
tv_y  out  10  active line number in field, 1-based
data_out  out  16  {Y[7:0], C[7:0]}, C = Cb on even pixel, Cr on odd pixel
sync_err  out  1  one-cycle pulse on TRS with bad protection bits

Behaviour:
- Reset (sync, active-high, any cycle incl. mid-line): all outputs 0, TRS FSM to S_SEARCH, capture inactive, counters 0.
- TRS FSM, one transition per byte:
  - S_SEARCH: FF -> S_FF.
  - S_FF: 00 -> S_00; FF stays S_FF; else S_SEARCH.
  - S_00: 00 -> S_0000; FF -> S_FF; else S_SEARCH.
  - S_0000: decode byte as XY, always -> S_SEARCH.
- XY decode: bit7 must be 1; F=b6, V=b5, H=b4.
  - Protection: b3=V^H, b2=F^H, b1=F^V, b0=F^V^H.
  - Mismatch or b7=0: sync_err=1 the next cycle; XY ignored; capture state unchanged.
- Valid XY actions:
  - V=1: tv_y counter := 0, tv_lin counter := 0, capture stops.
  - H=1 (EAV): capture stops.
  - H=0, V=0 (SAV): tv_field := F; y := min(y+1, Y_MAX); x := 0; byte phase := 0; capture starts with the next byte.
- TRS bytes arriving during capture: capture continues until the XY byte is decoded (FF/00 are illegal video, so no false TRS).
- Capture byte phase cycles 0..3 = Cb, Y0, Cr, Y1. C bytes are latched internally.
- On each Y byte, while x < H_ACTIVE:
  - registered outputs update the next cycle: tv_dval=1, data_out={Y, last C}, tv_x=x+1, tv_y=y, tv_lin=lin;
  - then x++, lin++.
- At x == H_ACTIVE, capture stops; further bytes are ignored until the next SAV.
- tv_dval is high for exactly one cycle per pixel, every second cycle during capture. Latency is 1 cycle from the Y byte to the strobe.
- tv_x, tv_y, tv_lin, data_out and tv_field hold their values while tv_dval=0.
- tv_lin wraps modulo 2^21. It never reaches the wrap at 720x288.
- EAV earlier than H_ACTIVE pixels: the line is truncated with no error. A missing EAV is tolerated because capture self-stops at H_ACTIVE.
- SAV during capture: restarts the line, x := 0, y increments.
- Reset and a valid XY in the same cycle: reset wins.

Test Plan:
- Reset check: hold reset 4 cycles with random td_data -> all outputs 0, no tv_dval.
- Single line: FF 00 00 AB (blank SAV F0) to clear y, then FF 00 00 80 followed by 1440 bytes of pattern Cb=10, Y=i, Cr=20 -> 720 tv_dval pulses spaced 2 cycles apart. First pulse: tv_x=1, tv_y=1, tv_lin=0, data_out=16'h0010. Second pulse: tv_x=2, data_out={Y,8'h20}. Last pulse: tv_x=720, tv_lin=719.
- Second line: follow with FF 00 00 9D then SAV 80 -> tv_y=2, tv_lin continues at 720 on that line's first pulse.
- Field 2: send SAV C7 after a blank TRS EC -> tv_field=1, tv_y=1, tv_lin=0.
- Protection error: send FF 00 00 81 -> sync_err pulses once 1 cycle later, no tv_dval follows, tv_y unchanged.
- Truncation / overrun:
  - EAV 9D after 100 pixels -> exactly 100 pulses.
  - SAV 80 followed by 1600 bytes with no EAV -> exactly 720 pulses.
  - Reset asserted at pixel 300 -> tv_dval 0 from the next cycle, outputs 0.
